led_bar_scan_mux: RTL and testbench
===================================

// Module: led_bar_scan_mux
// PURPOSE
//  Parametrised LED-bar source selector. Picks one of NCH WIDTH-bit debug buses
//  (CPU data out/in, port FF, SBC LEDs, ...) for the front-panel LED bar.
//  Source is chosen by the panel switches, or by auto-scan that steps through
//  the channels on a dwell timer.
//  Per-bit pulse stretching makes short bus activity visible; freeze holds the
//  display. Output polarity is selectable.
// PARAMETERS
//  WIDTH      8           bits per channel / LEDs on the bar
//  NCH        4           number of source channels (>=2)
//  SELW       2           select width; must equal clog2(NCH)
//  DWELL      25000000    auto-scan cycles per channel (>=1)
//  HOLD       2500000     stretch cycles per LED bit; 0 disables stretching
//  ACTIVE_LOW 1           1: output inverted (LED common to +V); 0: true
// PORTS
//  pll0_50MHz  in   1           system clock; all logic rises on this edge
//  reset       in   1           synchronous, active-high reset
//  chData      in   NCH*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//  sw          in   SELW        manual channel select (panel switches)
//  autoScan    in   1           1: auto-scan mode; 0: manual select via sw
//  freeze      in   1           1: hold display, stretch counters and scan timer
//  LEDoutData  out  WIDTH       registered LED drive, polarity per ACTIVE_LOW
//  curCh       out  SELW        registered index of channel now displayed
// BEHAVIOUR
//  Reset (sync, wins over all inputs):
//   - LEDoutData = ACTIVE_LOW ? all 1s : all 0s (LEDs dark)
//   - curCh = 0; dwell timer = 0; all stretch counters = 0
//  Manual select (autoScan=0):
//   - next sel = sw; if sw >= NCH then sel = NCH-1
//   - curCh <= sel each cycle
//  Auto-scan (autoScan=1):
//   - on autoScan 0->1: curCh <= clamped sw and dwell timer <= 0
//   - otherwise the timer counts up; at DWELL-1 it resets to 0 and curCh advances
//   - curCh wraps NCH-1 -> 0
//   - on autoScan 1->0: curCh <= clamped sw on the next cycle
//  Stretch, per bit i of the selected channel d = chData[curCh]:
//   - d[i]=1: cnt[i] <= HOLD
//   - otherwise, if cnt[i] != 0: cnt[i] <= cnt[i]-1
//   - shown[i] = d[i] | (cnt[i] != 0)
//   - HOLD=0: shown = d
//   - any cycle in which curCh changes clears every cnt[i], so a stale
//     channel never bleeds onto the new one
//  Output:
//   - LEDoutData <= ACTIVE_LOW ? ~shown : shown
//   - latency from chData to LEDoutData is 1 cycle; curCh to LEDoutData is 1 cycle
//  Freeze=1:
//   - LEDoutData, cnt[], dwell timer and curCh all hold their values
//   - sw and autoScan edges are ignored (the autoScan edge detector still tracks)
//   - on release, operation resumes from the held state
//  Reset asserted mid-scan or mid-stretch takes effect the next edge, as above.
//  Arithmetic: timer width clog2(DWELL), cnt width clog2(HOLD+1). No overflow is
//  possible; values are compared, never wrapped.
// TESTING (bench params: WIDTH=8 NCH=4 DWELL=4 HOLD=3 ACTIVE_LOW=1)
//  1. reset=1 for 2 cycles, any inputs -> LEDoutData=8'hFF, curCh=0; release,
//     chData ch0=8'h5A, sw=0 -> LEDoutData=8'hA5 one cycle later
//  2. sw=2 then 3, ch2=8'h0F, ch3=8'hF0 -> LEDoutData 8'hF0 then 8'h0F,
//     curCh=2 then 3; NCH=3 build with sw=3 -> curCh=2
//  3. ch0 bit0 high for exactly 1 cycle -> LEDoutData[0]=0 for 4 cycles, then 1;
//     repeat with sw switched to ch1 mid-hold -> stretch cleared immediately
//  4. autoScan 0->1 with sw=1 -> curCh sequence 1,2,3,0,1 changing every 4
//     cycles; autoScan->0 with sw=3 -> curCh=3 next cycle
//  5. freeze=1 during scan with ch data toggling -> LEDoutData and curCh constant;
//     freeze=0 -> dwell resumes with remaining count
//  6. reset pulsed mid-scan with active stretches -> curCh=0, LEDoutData=8'hFF,
//     then normal manual or scan restart from timer=0

Source files
------------

// File: rtl/led_bar_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : led_bar_scan_mux
//  Description : Front-panel LED bar source selector: manual/auto-scan channel
//                select, per-bit pulse stretching, freeze, selectable polarity.
//  Revision    : 1.0  initial release
// ============================================================================
module led_bar_scan_mux #(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int SELW       = 2,
    parameter int DWELL      = 25000000,
    parameter int HOLD       = 2500000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  pll0_50MHz,
    input  logic                  reset,
    input  logic [NCH*WIDTH-1:0]  chData,
    input  logic [SELW-1:0]       sw,
    input  logic                  autoScan,
    input  logic                  freeze,
    output logic [WIDTH-1:0]      LEDoutData,
    output logic [SELW-1:0]       curCh
);

    localparam int               TW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TW-1:0]    C_TLAST   = TW'(DWELL - 1);
    localparam logic [SELW-1:0]  C_LAST_CH = SELW'(NCH - 1);
    localparam logic [WIDTH-1:0] C_DARK    = {WIDTH{ACTIVE_LOW}};

    logic [SELW-1:0]  r_cur;
    logic [TW-1:0]    r_tmr;
    logic [WIDTH-1:0] r_led;
    logic             r_auto_d;

    logic [SELW-1:0]  w_sel;
    logic [SELW-1:0]  w_next_ch;
    logic [TW-1:0]    w_next_tmr;
    logic             w_ch_change;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_shown;
    logic [WIDTH-1:0] w_ch [2**SELW];

    // Unused select codes (NCH not a power of two) read as an idle bus.
    genvar k;
    generate
        for (k = 0; k < 2**SELW; k++) begin : g_chan
            if (k < NCH) begin : g_real
                assign w_ch[k] = chData[k*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_ch[k] = '0;
            end
        end
    endgenerate

    assign w_sel = (32'(sw) >= NCH) ? C_LAST_CH : sw;
    assign w_d   = w_ch[r_cur];

    always_comb begin
        w_next_ch  = w_sel;
        w_next_tmr = '0;
        // A rising autoScan (r_auto_d low) falls through to the defaults: restart at sw.
        if (autoScan && r_auto_d) begin
            if (r_tmr == C_TLAST) begin
                w_next_tmr = '0;
                w_next_ch  = (r_cur == C_LAST_CH) ? '0 : r_cur + 1'b1;
            end else begin
                w_next_tmr = r_tmr + 1'b1;
                w_next_ch  = r_cur;
            end
        end
    end

    assign w_ch_change = (w_next_ch != r_cur);

    generate
        if (HOLD > 0) begin : g_stretch
            localparam int            CW     = $clog2(HOLD + 1);
            localparam logic [CW-1:0] C_HOLD = CW'(HOLD);
            logic [CW-1:0] r_cnt [WIDTH];

            always_ff @(posedge pll0_50MHz) begin
                if (reset) begin
                    for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
                end else if (!freeze) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (w_ch_change)
                            r_cnt[i] <= '0;
                        else if (w_d[i])
                            r_cnt[i] <= C_HOLD;
                        else if (r_cnt[i] != '0)
                            r_cnt[i] <= r_cnt[i] - 1'b1;
                    end
                end
            end

            always_comb begin
                w_shown = '0;
                for (int i = 0; i < WIDTH; i++)
                    w_shown[i] = w_d[i] | (r_cnt[i] != '0);
            end
        end else begin : g_nostretch
            assign w_shown = w_d;
        end
    endgenerate

    // The autoScan edge detector keeps tracking through reset and freeze, so
    // an edge that happened while held is not replayed afterwards.
    always_ff @(posedge pll0_50MHz) begin
        r_auto_d <= autoScan;
        if (reset) begin
            r_cur <= '0;
            r_tmr <= '0;
            r_led <= C_DARK;
        end else if (!freeze) begin
            r_cur <= w_next_ch;
            r_tmr <= w_next_tmr;
            r_led <= ACTIVE_LOW ? ~w_shown : w_shown;
        end
    end

    assign LEDoutData = r_led;
    assign curCh      = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_led_bar_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_led_bar_scan_mux
//  Description : Self-checking bench: vector table, directed multi-cycle
//                sequences and randomized run against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_bar_scan_mux;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SELW  = 2;
    localparam int DWELL = 4;
    localparam int HOLD  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       chData;
    logic [SELW-1:0]   sw;
    logic              autoScan;
    logic              freeze;
    logic [WIDTH-1:0]  led;
    logic [SELW-1:0]   cur;
    logic [23:0]       ch3Data;
    logic [WIDTH-1:0]  led3;
    logic [SELW-1:0]   cur3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign ch3Data = chData[23:0];

    led_bar_scan_mux #(
        .WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL), .HOLD(HOLD), .ACTIVE_LOW(1'b1)
    ) dut (
        .pll0_50MHz(clk), .reset(rst), .chData(chData), .sw(sw),
        .autoScan(autoScan), .freeze(freeze), .LEDoutData(led), .curCh(cur)
    );

    led_bar_scan_mux #(
        .WIDTH(WIDTH), .NCH(3), .SELW(SELW), .DWELL(DWELL), .HOLD(HOLD), .ACTIVE_LOW(1'b1)
    ) dut3 (
        .pll0_50MHz(clk), .reset(rst), .chData(ch3Data), .sw(sw),
        .autoScan(1'b0), .freeze(1'b0), .LEDoutData(led3), .curCh(cur3)
    );

    // Behavioural model: integer state, rules applied once per clock.
    int         m_cur, m_timer;
    int         m_cnt [WIDTH];
    logic [7:0] m_led;
    bit         m_prev;

    task automatic model_step();
        int         sel, ncur, ntimer;
        logic [7:0] d, shown;
        if (rst) begin
            m_cur = 0; m_timer = 0; m_led = 8'hFF;
            for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
        end else if (!freeze) begin
            sel    = (int'(sw) > NCH - 1) ? NCH - 1 : int'(sw);
            ncur   = sel;
            ntimer = 0;
            if (autoScan && m_prev) begin
                if (m_timer + 1 == DWELL) begin
                    ntimer = 0;
                    ncur   = (m_cur + 1) % NCH;
                end else begin
                    ntimer = m_timer + 1;
                    ncur   = m_cur;
                end
            end
            d = chData[m_cur*8 +: 8];
            for (int i = 0; i < WIDTH; i++) begin
                shown[i] = d[i] || (m_cnt[i] > 0);
                if (ncur != m_cur)  m_cnt[i] = 0;
                else if (d[i])      m_cnt[i] = HOLD;
                else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
            m_led   = ~shown;
            m_cur   = ncur;
            m_timer = ntimer;
        end
        m_prev = autoScan;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       auto_s;
        logic [31:0] ch;
        logic [1:0] sw;
        logic [7:0] exp_led;
        logic [1:0] exp_cur;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'hDEADBEEF, 2'd3, 8'hFF, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 32'hDEADBEEF, 2'd3, 8'hFF, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000005A, 2'd0, 8'hA5, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000005A, 2'd0, 8'hA5, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'hF00F005A, 2'd2, 8'hA5, 2'd2};
        tbl[5]  = '{1'b0, 1'b0, 32'hF00F005A, 2'd2, 8'hF0, 2'd2};
        tbl[6]  = '{1'b0, 1'b0, 32'hF00F005A, 2'd3, 8'hF0, 2'd3};
        tbl[7]  = '{1'b0, 1'b0, 32'hF00F005A, 2'd3, 8'h0F, 2'd3};
        tbl[8]  = '{1'b0, 1'b0, 32'hF00F0000, 2'd0, 8'h0F, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 32'hF00F0000, 2'd0, 8'hFF, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 32'hF00F0001, 2'd0, 8'hFE, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 32'hF00F0000, 2'd0, 8'hFE, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 32'hF00F0000, 2'd0, 8'hFE, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 32'hF00F0000, 2'd0, 8'hFE, 2'd0};
        tbl[14] = '{1'b0, 1'b0, 32'hF00F0000, 2'd0, 8'hFF, 2'd0};
        tbl[15] = '{1'b0, 1'b0, 32'hF00F0001, 2'd0, 8'hFE, 2'd0};
        tbl[16] = '{1'b0, 1'b0, 32'hF00F0000, 2'd1, 8'hFE, 2'd1};
        tbl[17] = '{1'b0, 1'b0, 32'hF00F0000, 2'd1, 8'hFF, 2'd1};

        rst = 1'b1; chData = '0; sw = '0; autoScan = 1'b0; freeze = 1'b0;
        #1;

        // Reset, manual select, single-cycle stretch, stretch cleared on switch
        for (int r = 0; r < 18; r++) begin
            rst = tbl[r].rst; autoScan = tbl[r].auto_s; chData = tbl[r].ch; sw = tbl[r].sw;
            tick();
            check($sformatf("vec%0d_led", r), 32'(led), 32'(tbl[r].exp_led));
            check($sformatf("vec%0d_cur", r), 32'(cur), 32'(tbl[r].exp_cur));
        end

        // sw beyond NCH-1 clamps on a 3-channel build
        sw = 2'd3; chData = 32'h00C30000;
        tick();
        check("nch3_clamp_cur", 32'(cur3), 32'd2);
        check("nch4_sw3_cur", 32'(cur), 32'd3);
        tick();
        check("nch3_clamp_led", 32'(led3), 32'h3C);
        check("nch4_sw3_led", 32'(led), 32'hFF);

        // Auto-scan from sw=1, four cycles per channel, wrapping
        sw = 2'd1; autoScan = 1'b1; chData = '0;
        for (int k = 0; k < 17; k++) begin
            tick();
            check($sformatf("scan_k%0d_cur", k), 32'(cur), 32'((1 + k / DWELL) % NCH));
        end
        autoScan = 1'b0; sw = 2'd3;
        tick();
        check("scan_exit_cur", 32'(cur), 32'd3);

        // Freeze mid-dwell: everything holds, then dwell resumes
        autoScan = 1'b1; sw = 2'd0; chData = 32'h0000003C;
        tick();
        tick();
        check("frz_pre_cur", 32'(cur), 32'd0);
        check("frz_pre_led", 32'(led), 32'hC3);
        freeze = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chData = $urandom;
            sw     = 2'($urandom_range(0, 3));
            tick();
            check($sformatf("frz_k%0d_led", k), 32'(led), 32'hC3);
            check($sformatf("frz_k%0d_cur", k), 32'(cur), 32'd0);
        end
        freeze = 1'b0; chData = 32'h0000003C; sw = 2'd0;
        tick();
        check("frz_rel1_cur", 32'(cur), 32'd0);
        check("frz_rel1_led", 32'(led), 32'hC3);
        tick();
        check("frz_rel2_cur", 32'(cur), 32'd0);
        tick();
        check("frz_rel3_cur", 32'(cur), 32'd1);

        // Reset with active stretches, scan restarts from channel 0 / timer 0
        chData = 32'hFFFFFFFF;
        tick();
        chData = '0; rst = 1'b1;
        tick();
        check("mid_rst_led", 32'(led), 32'hFF);
        check("mid_rst_cur", 32'(cur), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst_k%0d_cur", k), 32'(cur), (k == 3) ? 32'd1 : 32'd0);
            if (k == 0) check("post_rst_led", 32'(led), 32'hFF);
        end

        // Randomized run against the model
        rst = 1'b1; freeze = 1'b0; autoScan = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 500; k++) begin
            rst    = ($urandom_range(0, 63) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) autoScan = ~autoScan;
            if ($urandom_range(0, 7) == 0)  sw = 2'($urandom_range(0, 3));
            chData = $urandom & $urandom & $urandom;
            tick();
            check("rand_led", 32'(led), 32'(m_led));
            check("rand_cur", 32'(cur), 32'(m_cur));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
